computer_datapath_control_sequencer: RTL and testbench

Multi-cycle control unit that fetches 16-bit instructions, decodes them and drives the 20-bit control word consumed by the datapath register file, function unit and data memory. It is the producer end of the CNTRL bus: it drives the DA/AA/BA fields and the RW strobe that the register file samples. It also owns the program counter and the constant (immediate) bus. Status flags return from the function unit for conditional branches.

---
 rtl/computer_datapath_pkg.sv | 78 +++++++
 rtl/computer_datapath_instr_decoder.sv | 78 +++++++
 rtl/computer_datapath_control_sequencer.sv | 117 +++++++++++
 tb/tb_computer_datapath_control_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/computer_datapath_pkg.sv
// Shared definitions for the computer datapath control sequencer: widths,
// opcode and function-select encodings, control-word layout and FSM states.
package computer_datapath_pkg;

    localparam int unsigned WORD_W   = 16;
    localparam int unsigned DR_W     = 3;
    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned FS_W     = 4;

    function automatic int unsigned cntrl_width(input int unsigned dr_w);
        return dr_w * 3 + 11;
    endfunction

    localparam int unsigned CNTRL_W = cntrl_width(DR_W);

    // Control-word bit positions, LSB upwards; bits [1:0] are reserved zero.
    localparam int unsigned MW_BIT = 2;
    localparam int unsigned MM_BIT = 3;
    localparam int unsigned RW_BIT = 4;
    localparam int unsigned MD_BIT = 5;
    localparam int unsigned FS_LSB = 6;
    localparam int unsigned FS_MSB = FS_LSB + FS_W - 1;
    localparam int unsigned MB_BIT = FS_MSB + 1;
    localparam int unsigned BA_LSB = MB_BIT + 1;
    localparam int unsigned BA_MSB = BA_LSB + DR_W - 1;
    localparam int unsigned AA_LSB = BA_MSB + 1;
    localparam int unsigned AA_MSB = AA_LSB + DR_W - 1;
    localparam int unsigned DA_LSB = AA_MSB + 1;
    localparam int unsigned DA_MSB = DA_LSB + DR_W - 1;

    // Instruction field positions.
    localparam int unsigned SB_LSB = 0;
    localparam int unsigned SA_LSB = DR_W;
    localparam int unsigned DR_LSB = 2 * DR_W;
    localparam int unsigned OP_LSB = 3 * DR_W;

    localparam logic [OPCODE_W-1:0] OP_MOVA = 7'h00;
    localparam logic [OPCODE_W-1:0] OP_INC  = 7'h01;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 7'h02;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 7'h05;
    localparam logic [OPCODE_W-1:0] OP_AND  = 7'h08;
    localparam logic [OPCODE_W-1:0] OP_OR   = 7'h09;
    localparam logic [OPCODE_W-1:0] OP_XOR  = 7'h0A;
    localparam logic [OPCODE_W-1:0] OP_NOT  = 7'h0B;
    localparam logic [OPCODE_W-1:0] OP_MOVB = 7'h0C;
    localparam logic [OPCODE_W-1:0] OP_LD   = 7'h10;
    localparam logic [OPCODE_W-1:0] OP_ST   = 7'h20;
    localparam logic [OPCODE_W-1:0] OP_LDI  = 7'h4C;
    localparam logic [OPCODE_W-1:0] OP_ADI  = 7'h42;
    localparam logic [OPCODE_W-1:0] OP_BRZ  = 7'h60;
    localparam logic [OPCODE_W-1:0] OP_BRN  = 7'h61;
    localparam logic [OPCODE_W-1:0] OP_HLT  = 7'h7F;

    localparam logic [FS_W-1:0] FS_MOVA = 4'b0000;
    localparam logic [FS_W-1:0] FS_INC  = 4'b0001;
    localparam logic [FS_W-1:0] FS_ADD  = 4'b0010;
    localparam logic [FS_W-1:0] FS_SUB  = 4'b0101;
    localparam logic [FS_W-1:0] FS_AND  = 4'b1000;
    localparam logic [FS_W-1:0] FS_OR   = 4'b1001;
    localparam logic [FS_W-1:0] FS_XOR  = 4'b1010;
    localparam logic [FS_W-1:0] FS_NOT  = 4'b1011;
    localparam logic [FS_W-1:0] FS_MOVB = 4'b1100;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_LDWB  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    // Branch offset is {DR,SB} as a 6-bit two's-complement value.
    function automatic logic [WORD_W-1:0] branch_offset(input logic [WORD_W-1:0] ir);
        logic [2*DR_W-1:0] off;
        off = {ir[DR_LSB +: DR_W], ir[SB_LSB +: DR_W]};
        return {{(WORD_W - 2*DR_W){off[2*DR_W-1]}}, off};
    endfunction

endpackage

// File: rtl/computer_datapath_instr_decoder.sv
// Combinational instruction decoder: produces the EXEC-cycle control word,
// the branch decision from {N,Z}, and load/halt classification.
module computer_datapath_instr_decoder
    import computer_datapath_pkg::*;
#(
    parameter int unsigned WORD_WIDTH   = WORD_W,
    parameter int unsigned DR_WIDTH     = DR_W,
    parameter int unsigned OPCODE_WIDTH = OPCODE_W,
    parameter int unsigned CNTRL_WIDTH  = cntrl_width(DR_WIDTH)
) (
    input  logic [WORD_WIDTH-1:0]  ir_i,
    input  logic [1:0]             status_i,
    output logic [CNTRL_WIDTH-1:0] cntrl_o,
    output logic                   branch_taken_o,
    output logic                   is_load_o,
    output logic                   is_halt_o
);

    logic [OPCODE_WIDTH-1:0] opcode;
    logic [DR_WIDTH-1:0]     dr;
    logic [DR_WIDTH-1:0]     sa;
    logic [DR_WIDTH-1:0]     sb;
    logic [FS_W-1:0]         fs;
    logic                    mb;
    logic                    rw;
    logic                    mw;
    logic                    fields_en;

    assign opcode = ir_i[OP_LSB +: OPCODE_WIDTH];
    assign dr     = ir_i[DR_LSB +: DR_WIDTH];
    assign sa     = ir_i[SA_LSB +: DR_WIDTH];
    assign sb     = ir_i[SB_LSB +: DR_WIDTH];

    always_comb begin
        fs             = FS_MOVA;
        mb             = 1'b0;
        rw             = 1'b0;
        mw             = 1'b0;
        fields_en      = 1'b1;
        branch_taken_o = 1'b0;
        is_load_o      = 1'b0;
        is_halt_o      = 1'b0;
        case (opcode)
            OP_MOVA: begin fs = FS_MOVA; rw = 1'b1; end
            OP_INC:  begin fs = FS_INC;  rw = 1'b1; end
            OP_ADD:  begin fs = FS_ADD;  rw = 1'b1; end
            OP_SUB:  begin fs = FS_SUB;  rw = 1'b1; end
            OP_AND:  begin fs = FS_AND;  rw = 1'b1; end
            OP_OR:   begin fs = FS_OR;   rw = 1'b1; end
            OP_XOR:  begin fs = FS_XOR;  rw = 1'b1; end
            OP_NOT:  begin fs = FS_NOT;  rw = 1'b1; end
            OP_MOVB: begin fs = FS_MOVB; rw = 1'b1; end
            OP_LD:   is_load_o = 1'b1;
            OP_ST:   mw = 1'b1;
            OP_LDI:  begin mb = 1'b1; fs = FS_MOVB; rw = 1'b1; end
            OP_ADI:  begin mb = 1'b1; fs = FS_ADD;  rw = 1'b1; end
            OP_BRZ:  branch_taken_o = status_i[0];
            OP_BRN:  branch_taken_o = status_i[1];
            OP_HLT:  is_halt_o = 1'b1;
            default: fields_en = 1'b0;
        endcase
    end

    // Undefined opcodes are NOPs: the whole word, register fields included, is zero.
    always_comb begin
        cntrl_o = '0;
        if (fields_en) begin
            cntrl_o[DA_LSB +: DR_WIDTH] = dr;
            cntrl_o[AA_LSB +: DR_WIDTH] = sa;
            cntrl_o[BA_LSB +: DR_WIDTH] = sb;
            cntrl_o[MB_BIT]             = mb;
            cntrl_o[FS_LSB +: FS_W]     = fs;
            cntrl_o[RW_BIT]             = rw;
            cntrl_o[MW_BIT]             = mw;
        end
    end

endmodule

// File: rtl/computer_datapath_control_sequencer.sv
// Multi-cycle fetch/execute sequencer: owns the FSM, PC and IR, and drives the
// control word and immediate bus consumed by the datapath.
module computer_datapath_control_sequencer
    import computer_datapath_pkg::*;
#(
    parameter int unsigned WORD_WIDTH   = WORD_W,
    parameter int unsigned DR_WIDTH     = DR_W,
    parameter int unsigned OPCODE_WIDTH = OPCODE_W,
    parameter int unsigned CNTRL_WIDTH  = cntrl_width(DR_WIDTH)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [WORD_WIDTH-1:0]  INSTR_bus_in,
    input  logic                   INSTR_valid_in,
    input  logic [1:0]             STATUS_in,
    output logic                   INSTR_req_out,
    output logic [WORD_WIDTH-1:0]  PC_out,
    output logic [CNTRL_WIDTH-1:0] CNTRL_bus_out,
    output logic [WORD_WIDTH-1:0]  CONST_bus_out,
    output logic                   HALT_out
);

    state_e                 state_q, state_d;
    logic [WORD_WIDTH-1:0]  pc_q, pc_d;
    logic [WORD_WIDTH-1:0]  ir_q, ir_d;

    logic [CNTRL_WIDTH-1:0] dec_cntrl;
    logic                   dec_branch;
    logic                   dec_load;
    logic                   dec_halt;

    logic [CNTRL_WIDTH-1:0] cntrl_c;
    logic [WORD_WIDTH-1:0]  const_c;

    computer_datapath_instr_decoder #(
        .WORD_WIDTH   (WORD_WIDTH),
        .DR_WIDTH     (DR_WIDTH),
        .OPCODE_WIDTH (OPCODE_WIDTH),
        .CNTRL_WIDTH  (CNTRL_WIDTH)
    ) u_decoder (
        .ir_i           (ir_q),
        .status_i       (STATUS_in),
        .cntrl_o        (dec_cntrl),
        .branch_taken_o (dec_branch),
        .is_load_o      (dec_load),
        .is_halt_o      (dec_halt)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_FETCH: begin
                if (INSTR_valid_in) begin
                    ir_d    = INSTR_bus_in;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                pc_d = dec_branch ? pc_q + branch_offset(ir_q)
                                  : pc_q + WORD_WIDTH'(1);
                if (dec_load) begin
                    state_d = ST_LDWB;
                end else if (dec_halt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_LDWB:  state_d = ST_FETCH;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        cntrl_c = '0;
        const_c = '0;
        case (state_q)
            ST_EXEC: begin
                cntrl_c                    = dec_cntrl;
                const_c[DR_WIDTH-1:0]      = ir_q[SB_LSB +: DR_WIDTH];
            end
            ST_LDWB: begin
                cntrl_c[DA_LSB +: DR_WIDTH] = ir_q[DR_LSB +: DR_WIDTH];
                cntrl_c[AA_LSB +: DR_WIDTH] = ir_q[SA_LSB +: DR_WIDTH];
                cntrl_c[BA_LSB +: DR_WIDTH] = ir_q[SB_LSB +: DR_WIDTH];
                cntrl_c[MD_BIT]             = 1'b1;
                cntrl_c[RW_BIT]             = 1'b1;
                const_c[DR_WIDTH-1:0]       = ir_q[SB_LSB +: DR_WIDTH];
            end
            default: ;
        endcase
    end

    // Outputs are forced low while RST is held so an aborted EXEC cannot
    // leak an RW/MW strobe into the cycle in which reset is sampled.
    assign CNTRL_bus_out = RST ? cntrl_c : '0;
    assign CONST_bus_out = RST ? const_c : '0;
    assign PC_out        = RST ? pc_q    : '0;
    assign INSTR_req_out = RST && (state_q == ST_FETCH);
    assign HALT_out      = RST && (state_q == ST_HALT);

endmodule

// File: tb/tb_computer_datapath_control_sequencer.sv
// Directed self-checking bench for the control sequencer; expected control
// words are hand-derived from the instruction encodings.
module tb_computer_datapath_control_sequencer;

    logic        CLK;
    logic        RST;
    logic [15:0] INSTR_bus_in;
    logic        INSTR_valid_in;
    logic [1:0]  STATUS_in;
    logic        INSTR_req_out;
    logic [15:0] PC_out;
    logic [19:0] CNTRL_bus_out;
    logic [15:0] CONST_bus_out;
    logic        HALT_out;

    int checks = 0;
    int errors = 0;

    computer_datapath_control_sequencer #(
        .WORD_WIDTH   (16),
        .DR_WIDTH     (3),
        .OPCODE_WIDTH (7),
        .CNTRL_WIDTH  (20)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .INSTR_bus_in   (INSTR_bus_in),
        .INSTR_valid_in (INSTR_valid_in),
        .STATUS_in      (STATUS_in),
        .INSTR_req_out  (INSTR_req_out),
        .PC_out         (PC_out),
        .CNTRL_bus_out  (CNTRL_bus_out),
        .CONST_bus_out  (CONST_bus_out),
        .HALT_out       (HALT_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Issue one instruction from FETCH: after return the DUT is in EXEC.
    task automatic issue(input logic [15:0] instr, input logic [1:0] status);
        INSTR_bus_in   = instr;
        STATUS_in      = status;
        INSTR_valid_in = 1'b1;
        tick();
        INSTR_valid_in = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b0; INSTR_valid_in = 1'b0; INSTR_bus_in = '0; STATUS_in = '0;
        tick(); tick();
        checks++; if (CNTRL_bus_out !== 20'h0) begin errors++; $display("FAIL rst_cntrl got %h exp %h", CNTRL_bus_out, 20'h0); end
        checks++; if (PC_out !== 16'h0) begin errors++; $display("FAIL rst_pc got %h exp %h", PC_out, 16'h0); end
        checks++; if (INSTR_req_out !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", INSTR_req_out); end
        checks++; if (HALT_out !== 1'b0) begin errors++; $display("FAIL rst_halt got %b exp 0", HALT_out); end
        RST = 1'b1;
        #1;
        checks++; if (INSTR_req_out !== 1'b1) begin errors++; $display("FAIL rst_rel_req got %b exp 1", INSTR_req_out); end
        checks++; if (CONST_bus_out !== 16'h0) begin errors++; $display("FAIL rst_const got %h exp %h", CONST_bus_out, 16'h0); end
    endtask

    task automatic test_add;
        issue(16'h04CA, 2'b00);
        checks++; if (CNTRL_bus_out !== 20'h65090) begin errors++; $display("FAIL add_cntrl got %h exp %h", CNTRL_bus_out, 20'h65090); end
        checks++; if (CONST_bus_out !== 16'h0002) begin errors++; $display("FAIL add_const got %h exp %h", CONST_bus_out, 16'h0002); end
        checks++; if (INSTR_req_out !== 1'b0) begin errors++; $display("FAIL add_req got %b exp 0", INSTR_req_out); end
        checks++; if (PC_out !== 16'h0000) begin errors++; $display("FAIL add_pc_exec got %h exp %h", PC_out, 16'h0000); end
        tick();
        checks++; if (CNTRL_bus_out !== 20'h0) begin errors++; $display("FAIL add_rw_pulse got %h exp %h", CNTRL_bus_out, 20'h0); end
        checks++; if (PC_out !== 16'h0001) begin errors++; $display("FAIL add_pc got %h exp %h", PC_out, 16'h0001); end
        checks++; if (INSTR_req_out !== 1'b1) begin errors++; $display("FAIL add_refetch got %b exp 1", INSTR_req_out); end
    endtask

    task automatic test_ldi_ld;
        issue(16'h9946, 2'b00);
        checks++; if (CNTRL_bus_out !== 20'hA3710) begin errors++; $display("FAIL ldi_cntrl got %h exp %h", CNTRL_bus_out, 20'hA3710); end
        checks++; if (CONST_bus_out !== 16'h0006) begin errors++; $display("FAIL ldi_const got %h exp %h", CONST_bus_out, 16'h0006); end
        tick();
        checks++; if (CONST_bus_out !== 16'h0000) begin errors++; $display("FAIL ldi_const_fetch got %h exp %h", CONST_bus_out, 16'h0000); end
        checks++; if (PC_out !== 16'h0002) begin errors++; $display("FAIL ldi_pc got %h exp %h", PC_out, 16'h0002); end
        issue(16'h20A0, 2'b00);
        checks++; if (CNTRL_bus_out !== 20'h50000) begin errors++; $display("FAIL ld_exec got %h exp %h", CNTRL_bus_out, 20'h50000); end
        tick();
        checks++; if (CNTRL_bus_out !== 20'h50030) begin errors++; $display("FAIL ld_wb got %h exp %h", CNTRL_bus_out, 20'h50030); end
        checks++; if (INSTR_req_out !== 1'b0) begin errors++; $display("FAIL ld_wb_req got %b exp 0", INSTR_req_out); end
        checks++; if (PC_out !== 16'h0003) begin errors++; $display("FAIL ld_pc got %h exp %h", PC_out, 16'h0003); end
        tick();
        checks++; if (INSTR_req_out !== 1'b1) begin errors++; $display("FAIL ld_refetch got %b exp 1", INSTR_req_out); end
        checks++; if (CNTRL_bus_out !== 20'h0) begin errors++; $display("FAIL ld_done_cntrl got %h exp %h", CNTRL_bus_out, 20'h0); end
    endtask

    task automatic test_store;
        issue(16'h401D, 2'b00);
        checks++; if (CNTRL_bus_out !== 20'hE804) begin errors++; $display("FAIL st_cntrl got %h exp %h", CNTRL_bus_out, 20'hE804); end
        tick();
        checks++; if (CNTRL_bus_out !== 20'h0) begin errors++; $display("FAIL st_mw_pulse got %h exp %h", CNTRL_bus_out, 20'h0); end
        checks++; if (PC_out !== 16'h0004) begin errors++; $display("FAIL st_pc got %h exp %h", PC_out, 16'h0004); end
    endtask

    task automatic test_branch;
        issue(16'hC044, 2'b01);
        checks++; if (CNTRL_bus_out !== 20'h22000) begin errors++; $display("FAIL brz_cntrl got %h exp %h", CNTRL_bus_out, 20'h22000); end
        tick();
        checks++; if (PC_out !== 16'h0010) begin errors++; $display("FAIL brz_fwd got %h exp %h", PC_out, 16'h0010); end
        issue(16'hC1C6, 2'b01);
        checks++; if (CNTRL_bus_out !== 20'hE3000) begin errors++; $display("FAIL brz_back_cntrl got %h exp %h", CNTRL_bus_out, 20'hE3000); end
        tick();
        checks++; if (PC_out !== 16'h000E) begin errors++; $display("FAIL brz_taken got %h exp %h", PC_out, 16'h000E); end
        issue(16'hC202, 2'b10);
        tick();
        checks++; if (PC_out !== 16'h0010) begin errors++; $display("FAIL brn_taken got %h exp %h", PC_out, 16'h0010); end
        issue(16'hC1C6, 2'b10);
        tick();
        checks++; if (PC_out !== 16'h0011) begin errors++; $display("FAIL brz_not_taken got %h exp %h", PC_out, 16'h0011); end
        issue(16'hC3C6, 2'b01);
        tick();
        checks++; if (PC_out !== 16'h0012) begin errors++; $display("FAIL brn_not_taken got %h exp %h", PC_out, 16'h0012); end
        STATUS_in = 2'b00;
    endtask

    task automatic test_wrap;
        issue(16'hC145, 2'b01);
        tick();
        checks++; if (PC_out !== 16'hFFFF) begin errors++; $display("FAIL br_to_ffff got %h exp %h", PC_out, 16'hFFFF); end
        issue(16'h0000, 2'b00);
        checks++; if (CNTRL_bus_out !== 20'h00010) begin errors++; $display("FAIL mova_cntrl got %h exp %h", CNTRL_bus_out, 20'h00010); end
        tick();
        checks++; if (PC_out !== 16'h0000) begin errors++; $display("FAIL pc_wrap got %h exp %h", PC_out, 16'h0000); end
    endtask

    task automatic test_stall;
        INSTR_valid_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (CNTRL_bus_out !== 20'h0 || PC_out !== 16'h0000 || INSTR_req_out !== 1'b1) begin
                errors++; $display("FAIL stall_%0d got cntrl %h pc %h req %b exp 0 0000 1", i, CNTRL_bus_out, PC_out, INSTR_req_out);
            end
        end
        issue(16'h0248, 2'b00);
        checks++; if (CNTRL_bus_out !== 20'h24050) begin errors++; $display("FAIL inc_cntrl got %h exp %h", CNTRL_bus_out, 20'h24050); end
        INSTR_bus_in   = 16'hFE00;
        INSTR_valid_in = 1'b1;
        tick();
        INSTR_valid_in = 1'b0;
        checks++; if (INSTR_req_out !== 1'b1 || CNTRL_bus_out !== 20'h0) begin
            errors++; $display("FAIL valid_ignored got req %b cntrl %h exp 1 00000", INSTR_req_out, CNTRL_bus_out);
        end
        checks++; if (PC_out !== 16'h0001) begin errors++; $display("FAIL inc_pc got %h exp %h", PC_out, 16'h0001); end
        tick();
        checks++; if (INSTR_req_out !== 1'b1 || HALT_out !== 1'b0) begin
            errors++; $display("FAIL still_fetch got req %b halt %b exp 1 0", INSTR_req_out, HALT_out);
        end
    endtask

    task automatic test_nop;
        issue(16'h67FF, 2'b11);
        checks++; if (CNTRL_bus_out !== 20'h0) begin errors++; $display("FAIL nop_cntrl got %h exp %h", CNTRL_bus_out, 20'h0); end
        checks++; if (CONST_bus_out !== 16'h0007) begin errors++; $display("FAIL nop_const got %h exp %h", CONST_bus_out, 16'h0007); end
        tick();
        checks++; if (PC_out !== 16'h0002) begin errors++; $display("FAIL nop_pc got %h exp %h", PC_out, 16'h0002); end
        STATUS_in = 2'b00;
    endtask

    task automatic test_halt;
        issue(16'hFE00, 2'b00);
        tick();
        INSTR_bus_in   = 16'h04CA;
        INSTR_valid_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (HALT_out !== 1'b1 || INSTR_req_out !== 1'b0 || CNTRL_bus_out !== 20'h0 || PC_out !== 16'h0003) begin
                errors++; $display("FAIL halt_%0d got halt %b req %b cntrl %h pc %h exp 1 0 00000 0003", i, HALT_out, INSTR_req_out, CNTRL_bus_out, PC_out);
            end
            tick();
        end
        INSTR_valid_in = 1'b0;
    endtask

    task automatic test_reset_mid;
        RST = 1'b0;
        tick();
        RST = 1'b1;
        #1;
        checks++; if (HALT_out !== 1'b0 || INSTR_req_out !== 1'b1) begin
            errors++; $display("FAIL halt_exit got halt %b req %b exp 0 1", HALT_out, INSTR_req_out);
        end
        issue(16'h0000, 2'b00);
        tick();
        issue(16'h04CA, 2'b00);
        checks++; if (CNTRL_bus_out !== 20'h65090 || PC_out !== 16'h0001) begin
            errors++; $display("FAIL mid_exec got cntrl %h pc %h exp 65090 0001", CNTRL_bus_out, PC_out);
        end
        RST = 1'b0;
        #1;
        checks++; if (CNTRL_bus_out !== 20'h0) begin errors++; $display("FAIL mid_rst_rw got %h exp %h", CNTRL_bus_out, 20'h0); end
        tick();
        checks++; if (CNTRL_bus_out !== 20'h0 || PC_out !== 16'h0000) begin
            errors++; $display("FAIL mid_rst_hold got cntrl %h pc %h exp 00000 0000", CNTRL_bus_out, PC_out);
        end
        tick();
        RST = 1'b1;
        #1;
        checks++; if (INSTR_req_out !== 1'b1 || CNTRL_bus_out !== 20'h0 || PC_out !== 16'h0000) begin
            errors++; $display("FAIL mid_rst_release got req %b cntrl %h pc %h exp 1 00000 0000", INSTR_req_out, CNTRL_bus_out, PC_out);
        end
        tick();
        checks++; if (CNTRL_bus_out !== 20'h0 || INSTR_req_out !== 1'b1) begin
            errors++; $display("FAIL mid_rst_after got cntrl %h req %b exp 00000 1", CNTRL_bus_out, INSTR_req_out);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldi_ld();
        test_store();
        test_branch();
        test_wrap();
        test_stall();
        test_nop();
        test_halt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
